// File: rtl/exp5_fluxo_dados_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : exp5_fluxo_dados_pkg
//  Desc     : Shared constants for the exp5 memory game: word width, default
//             sequence length and the fixed 16-word sequence ROM.
//  Revision : 1.0 - initial release
// ============================================================================
package exp5_fluxo_dados_pkg;

  // Width of the keys, the play register and every ROM word.
  localparam int LARG_FIXA = 4;

  // Default number of plays in a round (legal range 2..16).
  localparam int N_JOGADAS_PADRAO = 16;

  // Fixed game sequence, address 0 first.
  function automatic logic [3:0] rom_ler(input logic [3:0] endereco);
    logic [3:0] palavra;
    palavra = 4'b0001;
    case (endereco)
      4'd0:  palavra = 4'b0001;
      4'd1:  palavra = 4'b0010;
      4'd2:  palavra = 4'b0100;
      4'd3:  palavra = 4'b1000;
      4'd4:  palavra = 4'b0100;
      4'd5:  palavra = 4'b0010;
      4'd6:  palavra = 4'b0001;
      4'd7:  palavra = 4'b0001;
      4'd8:  palavra = 4'b0010;
      4'd9:  palavra = 4'b0010;
      4'd10: palavra = 4'b0100;
      4'd11: palavra = 4'b0100;
      4'd12: palavra = 4'b1000;
      4'd13: palavra = 4'b1000;
      4'd14: palavra = 4'b0001;
      4'd15: palavra = 4'b0100;
      default: palavra = 4'b0001;
    endcase
    return palavra;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exp5_detector_borda.sv
`default_nettype none
// ============================================================================
//  Module   : exp5_detector_borda
//  Desc     : Rising-edge detector: one-cycle pulse when sinal goes 0 -> 1.
//  Revision : 1.0 - initial release
// ============================================================================
module exp5_detector_borda (
  input  logic clock,
  input  logic reset,   // asynchronous, active low
  input  logic sinal,
  output logic pulso
);

  logic atual_q;
  logic atual_d;
  logic anterior_q;
  logic anterior_d;

  // Next state: shift the input through two stages.
  always_comb begin
    atual_d    = sinal;
    anterior_d = atual_q;
  end

  // Two-stage history; cleared by reset so a held input pulses once after release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      atual_q    <= 1'b0;
      anterior_q <= 1'b0;
    end else begin
      atual_q    <= atual_d;
      anterior_q <= anterior_d;
    end
  end

  assign pulso = atual_q & ~anterior_q;

endmodule
`default_nettype wire

// File: rtl/exp5_fluxo_dados.sv
`default_nettype none
// ============================================================================
//  Module   : exp5_fluxo_dados
//  Desc     : exp5 memory-game datapath: position counter, sequence ROM, play
//             register, comparator and keypress edge detector.
//  Revision : 1.0 - initial release
// ============================================================================
module exp5_fluxo_dados
  import exp5_fluxo_dados_pkg::*;
#(
  parameter int N_JOGADAS = N_JOGADAS_PADRAO,
  parameter int LARG      = LARG_FIXA
) (
  input  logic            clock,
  input  logic            reset,        // asynchronous, active low
  input  logic            zeraC,
  input  logic            contaC,
  input  logic            zeraR,
  input  logic            registraR,
  input  logic [LARG-1:0] chaves,
  output logic            fim,
  output logic            jogada_feita,
  output logic            igual,
  output logic [3:0]      db_contagem,
  output logic [3:0]      db_memoria,
  output logic [LARG-1:0] db_jogada
);

  // Last reachable address; the counter wraps back to 0 after it.
  localparam logic [3:0] ULTIMO = 4'(N_JOGADAS - 1);

  logic [3:0]      cnt_q;
  logic [3:0]      cnt_d;
  logic [LARG-1:0] jogada_q;
  logic [LARG-1:0] jogada_d;
  logic [3:0]      memoria;

  // Counter next value: clear wins over count; count wraps at the last play.
  always_comb begin
    cnt_d = cnt_q;
    if (zeraC) begin
      cnt_d = 4'd0;
    end else if (contaC) begin
      cnt_d = (cnt_q == ULTIMO) ? 4'd0 : cnt_q + 4'd1;
    end
  end

  // Play register next value: clear wins over load.
  always_comb begin
    jogada_d = jogada_q;
    if (zeraR) begin
      jogada_d = '0;
    end else if (registraR) begin
      jogada_d = chaves;
    end
  end

  // State registers for counter and play register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= 4'd0;
      jogada_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      jogada_q <= jogada_d;
    end
  end

  // Combinational ROM read so igual follows the address in the same cycle.
  always_comb begin
    memoria = rom_ler(cnt_q);
  end

  exp5_detector_borda u_detector (
    .clock (clock),
    .reset (reset),
    .sinal (|chaves),
    .pulso (jogada_feita)
  );

  assign fim         = (cnt_q == ULTIMO);
  assign igual       = (jogada_q == memoria);
  assign db_contagem = cnt_q;
  assign db_memoria  = memoria;
  assign db_jogada   = jogada_q;

endmodule
`default_nettype wire
